// File: rtl/apb_fabric_pkg.sv
// Shared types and helpers for the APB fabric and its address decoder.
// Slot helpers locate one slave's field inside the flattened per-slave vectors.
package apb_fabric_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_DECODE  = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_SLAVE   = 2'b11
  } err_code_t;

  localparam int MAX_SLAVES = 16;

  // Lowest bit of slot 'slot' in a vector of equal-width fields.
  function automatic int unsigned slot_lsb(input int unsigned slot, input int unsigned width);
    return slot * width;
  endfunction

  // Index width that stays at least one bit wide for a single slave.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_fabric_if.sv
// APB bus bundle between the CPU-facing port and the routed slave ports.
// The fabric uses the slave modport; the environment driving CPU and slaves uses master.
interface apb_fabric_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 5
);

  logic [ADDR_WIDTH-1:0]            m_paddr;
  logic                             m_psel;
  logic                             m_penable;
  logic [DATA_WIDTH-1:0]            m_prdata;
  logic                             m_pready;
  logic                             m_perr;

  logic [NUM_SLAVES-1:0]            s_psel;
  logic [NUM_SLAVES-1:0]            s_penable;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_prdata;
  logic [NUM_SLAVES-1:0]            s_pready;
  logic [NUM_SLAVES-1:0]            s_perr;

  modport master (
    output m_paddr, m_psel, m_penable, s_prdata, s_pready, s_perr,
    input  m_prdata, m_pready, m_perr, s_psel, s_penable
  );

  modport slave (
    input  m_paddr, m_psel, m_penable, s_prdata, s_pready, s_perr,
    output m_prdata, m_pready, m_perr, s_psel, s_penable
  );

endinterface

// File: rtl/apb_addr_decode.sv
// Combinational base/mask address decoder with lowest-index priority.
// Kept standalone so other bridges can share the same address map logic.
module apb_addr_decode
  import apb_fabric_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 5,
  parameter int IDX_WIDTH  = idx_width(NUM_SLAVES),
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
  output logic [NUM_SLAVES-1:0] hit,
  output logic [IDX_WIDTH-1:0]  idx,
  output logic                  miss
);

  logic [NUM_SLAVES-1:0] match;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slot
    assign match[i] = (paddr & SLAVE_MASK[slot_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH])
                      == SLAVE_BASE[slot_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
  end

  // Scan from the top so the lowest matching slot is the one left standing.
  always_comb begin
    hit = '0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit    = '0;
        hit[i] = 1'b1;
        idx    = IDX_WIDTH'(i);
      end
    end
    miss = ~|match;
  end

endmodule

// File: rtl/apb_fabric.sv
// APB interconnect: one CPU port fanned out to NUM_SLAVES slaves with decode
// and timeout errors, plus sticky error capture that doubles as an interrupt.
module apb_fabric
  import apb_fabric_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 5,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT    = 255,
  parameter int TO_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rts,
  apb_fabric_if.slave           bus,
  input  logic                  err_clr,
  output logic                  err_valid,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_ovf
);

  localparam int IDX_WIDTH = idx_width(NUM_SLAVES);
  localparam logic [TO_WIDTH-1:0] TO_LAST = (TIMEOUT > 0) ? TO_WIDTH'(TIMEOUT - 1) : '0;

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic                  miss_q;
  logic [TO_WIDTH-1:0]   cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic [NUM_SLAVES-1:0] dec_hit;
  logic [IDX_WIDTH-1:0]  dec_idx;
  logic                  dec_miss;
  logic                  setup;

  logic                  slot_ready;
  logic                  slot_err;
  logic [DATA_WIDTH-1:0] slot_data;
  logic                  timeout_now;

  logic [NUM_SLAVES-1:0] sel_c;
  logic [NUM_SLAVES-1:0] en_c;
  logic [DATA_WIDTH-1:0] rdata_c;
  logic                  rdy_c;
  logic                  perr_c;
  logic                  err_event;
  err_code_t             err_kind;
  logic                  xfer_end;
  logic                  cnt_inc;

  apb_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_WIDTH  (IDX_WIDTH),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .paddr (bus.m_paddr),
    .hit   (dec_hit),
    .idx   (dec_idx),
    .miss  (dec_miss)
  );

  assign setup       = bus.m_psel && !bus.m_penable;
  assign slot_ready  = bus.s_pready[idx_q];
  assign slot_err    = bus.s_perr[idx_q];
  assign slot_data   = bus.s_prdata[slot_lsb(32'(idx_q), DATA_WIDTH) +: DATA_WIDTH];
  // A ready arriving on the last allowed cycle beats the abort.
  assign timeout_now = (TIMEOUT > 0) && !slot_ready && (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (rts) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (setup) state_d = ST_ACCESS;
      ST_ACCESS: if (xfer_end) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Reset is folded in here so an in-flight select drops in the same cycle.
  always_comb begin
    sel_c     = '0;
    en_c      = '0;
    rdata_c   = '0;
    rdy_c     = 1'b0;
    perr_c    = 1'b0;
    err_event = 1'b0;
    err_kind  = ERR_NONE;
    xfer_end  = 1'b0;
    cnt_inc   = 1'b0;
    if (!rts) begin
      case (state_q)
        ST_IDLE: begin
          if (setup) sel_c = dec_hit;
        end
        ST_ACCESS: begin
          if (!bus.m_psel) begin
            xfer_end = 1'b1;
          end else if (miss_q) begin
            rdy_c     = 1'b1;
            perr_c    = 1'b1;
            err_event = 1'b1;
            err_kind  = ERR_DECODE;
            xfer_end  = 1'b1;
          end else if (timeout_now) begin
            rdy_c     = 1'b1;
            perr_c    = 1'b1;
            err_event = 1'b1;
            err_kind  = ERR_TIMEOUT;
            xfer_end  = 1'b1;
          end else begin
            sel_c[idx_q] = 1'b1;
            en_c[idx_q]  = bus.m_penable;
            rdata_c      = slot_data;
            rdy_c        = slot_ready;
            perr_c       = slot_err;
            if (slot_ready) begin
              xfer_end = 1'b1;
              if (slot_err) begin
                err_event = 1'b1;
                err_kind  = ERR_SLAVE;
              end
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s_psel    = sel_c;
  assign bus.s_penable = en_c;
  assign bus.m_prdata  = rdata_c;
  assign bus.m_pready  = rdy_c;
  assign bus.m_perr    = perr_c;

  // Transfer context is latched at SETUP; the wait counter saturates.
  always_ff @(posedge clk) begin
    if (rts) begin
      idx_q  <= '0;
      miss_q <= 1'b0;
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (state_q == ST_IDLE && setup) begin
        idx_q  <= dec_idx;
        miss_q <= dec_miss;
        addr_q <= bus.m_paddr;
      end
      if (cnt_inc) begin
        if (cnt_q != '1) cnt_q <= cnt_q + TO_WIDTH'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // A clear coinciding with a new error still captures that error cleanly.
  always_ff @(posedge clk) begin
    if (rts) begin
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      err_addr  <= '0;
      err_ovf   <= 1'b0;
    end else if (err_event && (err_clr || !err_valid)) begin
      err_valid <= 1'b1;
      err_code  <= err_kind;
      err_addr  <= addr_q;
      err_ovf   <= 1'b0;
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      err_addr  <= '0;
      err_ovf   <= 1'b0;
    end else if (err_event) begin
      err_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_fabric.sv
// Bench for apb_fabric: directed scenarios then random transfers, each checked
// against a transaction-level model of the address map, timeout and error capture.
module tb_apb_fabric;
  import apb_fabric_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam int TO = 8;
  localparam logic [NS*AW-1:0] BASE = {32'h2000_0000, 32'h1000_0000, 32'h8000_0000};
  localparam logic [NS*AW-1:0] MASK = {32'hFFFF_0000, 32'hFFFF_0000, 32'h8000_0000};

  logic          clk = 1'b0;
  logic          rts = 1'b1;
  logic          err_clr = 1'b0;
  logic          err_valid;
  logic [1:0]    err_code;
  logic [AW-1:0] err_addr;
  logic          err_ovf;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_base [NS] = '{32'h8000_0000, 32'h1000_0000, 32'h2000_0000};
  logic [31:0] ref_mask [NS] = '{32'h8000_0000, 32'hFFFF_0000, 32'hFFFF_0000};
  logic [DW-1:0] slot_data [NS];

  logic        ref_valid = 1'b0;
  logic [1:0]  ref_code  = 2'b00;
  logic [31:0] ref_addr  = '0;
  logic        ref_ovf   = 1'b0;

  always #5 clk = ~clk;

  apb_fabric_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();

  apb_fabric #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_SLAVES (NS),
    .SLAVE_BASE (BASE),
    .SLAVE_MASK (MASK),
    .TIMEOUT    (TO),
    .TO_WIDTH   (8)
  ) dut (
    .clk       (clk),
    .rts       (rts),
    .bus       (bus),
    .err_clr   (err_clr),
    .err_valid (err_valid),
    .err_code  (err_code),
    .err_addr  (err_addr),
    .err_ovf   (err_ovf)
  );

  function automatic int ref_decode(input logic [31:0] addr);
    for (int i = 0; i < NS; i++) begin
      if ((addr & ref_mask[i]) == ref_base[i]) return i;
    end
    return -1;
  endfunction

  task automatic ref_error(input logic [1:0] code, input logic [31:0] addr, input bit clr);
    if (code != 2'b00 && (clr || !ref_valid)) begin
      ref_valid = 1'b1;
      ref_code  = code;
      ref_addr  = addr;
      ref_ovf   = 1'b0;
    end else if (clr) begin
      ref_valid = 1'b0;
      ref_code  = 2'b00;
      ref_addr  = '0;
      ref_ovf   = 1'b0;
    end else if (code != 2'b00) begin
      ref_ovf = 1'b1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkErr(input string tag);
    checkOutput({tag, "_err_valid"}, 64'(err_valid), 64'(ref_valid));
    checkOutput({tag, "_err_code"},  64'(err_code),  64'(ref_code));
    checkOutput({tag, "_err_addr"},  64'(err_addr),  64'(ref_addr));
    checkOutput({tag, "_err_ovf"},   64'(err_ovf),   64'(ref_ovf));
  endtask

  task automatic idleCycle();
    @(negedge clk);
    bus.m_psel    = 1'b0;
    bus.m_penable = 1'b0;
    bus.s_pready  = '0;
    bus.s_perr    = '0;
    err_clr       = 1'b0;
    #1;
  endtask

  task automatic pulseClear();
    @(negedge clk);
    bus.m_psel    = 1'b0;
    bus.m_penable = 1'b0;
    err_clr       = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    ref_error(2'b00, '0, 1'b1);
    #1;
  endtask

  task automatic loadSlaveData(input int slot, input logic [DW-1:0] tgt_data);
    for (int i = 0; i < NS; i++) begin
      slot_data[i] = (i == slot) ? tgt_data : $urandom;
      bus.s_prdata[i*DW +: DW] = slot_data[i];
    end
  endtask

  // One full transfer; wait_cyc<0 means the slave never answers.
  task automatic applyStimulus(input logic [31:0] addr, input int wait_cyc, input bit slv_err,
                               input bit clr_end, input logic [DW-1:0] tgt_data);
    int          slot;
    int          len;
    bit          ready_ends;
    bit          last;
    logic [NS-1:0] onehot;
    logic [NS-1:0] exp_sel;
    logic [1:0]  code;
    slot       = ref_decode(addr);
    ready_ends = 1'b0;
    if (slot < 0) len = 1;
    else if (wait_cyc >= 0 && wait_cyc < TO) begin
      len = wait_cyc + 1;
      ready_ends = 1'b1;
    end else len = TO;
    onehot = '0;
    if (slot >= 0) onehot[slot] = 1'b1;

    @(negedge clk);
    err_clr       = 1'b0;
    bus.m_paddr   = addr;
    bus.m_psel    = 1'b1;
    bus.m_penable = 1'b0;
    bus.s_pready  = NS'($urandom);
    bus.s_perr    = NS'($urandom);
    loadSlaveData(slot, tgt_data);
    #1;
    checkOutput("setup_psel", 64'(bus.s_psel), 64'(onehot));
    checkOutput("setup_pready", 64'(bus.m_pready), 64'(0));
    checkErr("setup");

    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      last          = (k == len);
      bus.m_penable = 1'b1;
      err_clr       = clr_end && last;
      bus.s_pready  = NS'($urandom);
      bus.s_perr    = NS'($urandom);
      if (slot >= 0) begin
        bus.s_pready[slot] = ready_ends && last;
        bus.s_perr[slot]   = slv_err && ready_ends && last;
      end
      #1;
      exp_sel = (slot < 0 || (last && !ready_ends)) ? '0 : onehot;
      checkOutput("acc_pready", 64'(bus.m_pready), 64'(last));
      checkOutput("acc_psel", 64'(bus.s_psel), 64'(exp_sel));
      checkOutput("acc_penable", 64'(bus.s_penable), 64'(exp_sel));
      if (last) begin
        checkOutput("acc_perr", 64'(bus.m_perr), 64'((slot < 0) || !ready_ends || slv_err));
        checkOutput("acc_prdata", 64'(bus.m_prdata),
                    (slot < 0 || !ready_ends) ? 64'(0) : 64'(slot_data[slot]));
      end
    end

    if (slot < 0)        code = ERR_DECODE;
    else if (!ready_ends) code = ERR_TIMEOUT;
    else if (slv_err)    code = ERR_SLAVE;
    else                 code = ERR_NONE;
    ref_error(code, addr, clr_end);
  endtask

  initial begin
    logic [31:0] addr;
    int          pick;
    $display("[TB] apb_fabric bench start");
    bus.m_paddr   = '0;
    bus.m_psel    = 1'b0;
    bus.m_penable = 1'b0;
    bus.s_prdata  = '0;
    bus.s_pready  = '0;
    bus.s_perr    = '0;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_psel", 64'(bus.s_psel), 64'(0));
    checkOutput("rst_penable", 64'(bus.s_penable), 64'(0));
    checkOutput("rst_pready", 64'(bus.m_pready), 64'(0));
    checkOutput("rst_perr", 64'(bus.m_perr), 64'(0));
    checkOutput("rst_prdata", 64'(bus.m_prdata), 64'(0));
    checkOutput("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
    checkErr("rst");
    @(negedge clk);
    rts = 1'b0;

    applyStimulus(32'h8000_0010, 0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    applyStimulus(32'h1000_0004, 3, 1'b0, 1'b0, 32'h1234_5678);
    applyStimulus(32'h3000_0000, 0, 1'b0, 1'b0, 32'h0);
    idleCycle();
    checkErr("decode");
    pulseClear();
    checkErr("clr1");

    applyStimulus(32'h2000_0000, -1, 1'b0, 1'b0, 32'h5555_AAAA);
    idleCycle();
    checkErr("timeout");
    applyStimulus(32'h3000_0004, 0, 1'b0, 1'b0, 32'h0);
    idleCycle();
    checkErr("overflow");

    pulseClear();
    applyStimulus(32'h1000_0008, 1, 1'b1, 1'b0, 32'hCAFE_0001);
    idleCycle();
    checkErr("slverr");
    pulseClear();
    checkErr("clr2");

    applyStimulus(32'h3000_0010, 0, 1'b0, 1'b0, 32'h0);
    applyStimulus(32'h3000_0020, 0, 1'b0, 1'b1, 32'h0);
    idleCycle();
    checkErr("clr_and_err");

    @(negedge clk);
    bus.m_paddr   = 32'h1000_0040;
    bus.m_psel    = 1'b1;
    bus.m_penable = 1'b0;
    bus.s_pready  = '0;
    bus.s_perr    = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.m_penable = 1'b1;
      #1;
      checkOutput("abandon_wait_psel", 64'(bus.s_psel), 64'(3'b010));
    end
    @(negedge clk);
    bus.m_psel    = 1'b0;
    bus.m_penable = 1'b0;
    #1;
    checkOutput("abandon_psel", 64'(bus.s_psel), 64'(0));
    checkOutput("abandon_pready", 64'(bus.m_pready), 64'(0));
    @(negedge clk);
    #1;
    checkOutput("abandon_state", 64'(dut.state_q), 64'(ST_IDLE));
    applyStimulus(32'h2000_0010, TO - 1, 1'b0, 1'b0, 32'h0BAD_F00D);

    @(negedge clk);
    bus.m_paddr   = 32'h8000_0020;
    bus.m_psel    = 1'b1;
    bus.m_penable = 1'b0;
    bus.s_pready  = '0;
    bus.s_perr    = '0;
    @(negedge clk);
    bus.m_penable = 1'b1;
    #1;
    checkOutput("rstmid_before_psel", 64'(bus.s_psel), 64'(3'b001));
    @(negedge clk);
    rts = 1'b1;
    #1;
    checkOutput("rstmid_same_psel", 64'(bus.s_psel), 64'(0));
    checkOutput("rstmid_same_penable", 64'(bus.s_penable), 64'(0));
    @(negedge clk);
    #1;
    checkOutput("rstmid_next_psel", 64'(bus.s_psel), 64'(0));
    checkOutput("rstmid_state", 64'(dut.state_q), 64'(ST_IDLE));
    ref_valid = 1'b0;
    ref_code  = 2'b00;
    ref_addr  = '0;
    ref_ovf   = 1'b0;
    checkErr("rstmid");
    rts = 1'b0;
    idleCycle();
    applyStimulus(32'h8000_0030, 0, 1'b0, 1'b0, 32'h7777_1111);

    for (int n = 0; n < 40; n++) begin
      pick = int'($urandom_range(0, 3));
      case (pick)
        0:       addr = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFF);
        1:       addr = 32'h1000_0000 | ($urandom & 32'h0000_FFFF);
        2:       addr = 32'h2000_0000 | ($urandom & 32'h0000_FFFF);
        default: addr = 32'h3000_0000 | ($urandom & 32'h0FFF_FFFF);
      endcase
      applyStimulus(addr, int'($urandom_range(0, TO + 2)) - 1, 1'($urandom),
                    ($urandom_range(0, 3) == 0), $urandom);
      if ($urandom_range(0, 2) == 0) idleCycle();
    end

    idleCycle();
    checkErr("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
